// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore control outputs plus a retired-instruction counter.
// Define MC_CTRL_BNE_EN to decode bne (000101) as a branch taken on ~zero[1].
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [2:0]  zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [1:0]  RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtOp,
  output logic        MemToReg,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_ALUWB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP   = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcwr;
    logic       irwr;
    logic       regwr;
    logic       memwr;
    logic [1:0] regdst;
    logic       srca;
    logic [1:0] srcb;
    logic       extop;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
`endif

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;

  state_t      r_state;
  ctrl_t       r_ctrl;
  logic [31:0] r_retired;

  state_t w_nxt;
  ctrl_t  w_nxt_ctrl;
  ctrl_t  w_rst_ctrl;
  logic   w_r_ok;
  logic   w_is_br;
  logic   w_take;
  logic   w_retire;
  logic   w_unused;

  assign w_unused = &{1'b0, zero[2], zero[0]};

  assign w_r_ok = (op == OP_R) &&
                  (funct == F_ADDU || funct == F_SUBU || funct == F_AND || funct == F_OR);

`ifdef MC_CTRL_BNE_EN
  assign w_is_br = (op == OP_BEQ) || (op == OP_BNE);
  assign w_take  = (op == OP_BNE) ? ~zero[1] : zero[1];
`else
  assign w_is_br = (op == OP_BEQ);
  assign w_take  = zero[1];
`endif

  // Control word for a state; looked up for the state being entered so outputs come straight from flops.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] o, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.irwr = 1'b1; c.pcwr = 1'b1; c.srcb = 2'b01; end
      S_DECODE: begin c.srcb = 2'b11; c.extop = 1'b1; end
      S_MEMADR: begin c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1; end
      S_MEMWB:  begin c.regwr = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:  c.memwr = 1'b1;
      S_EXEC: begin
        c.srca = 1'b1;
        if (o == OP_R) begin
          case (f)
            F_SUBU:  c.aluop = 3'b001;
            F_AND:   c.aluop = 3'b010;
            F_OR:    c.aluop = 3'b011;
            default: c.aluop = 3'b000;
          endcase
        end else if (o == OP_ORI) begin
          c.srcb = 2'b10; c.aluop = 3'b011;
        end else begin
          c.srcb = 2'b10; c.aluop = 3'b100;
        end
      end
      S_ALUWB: begin
        c.regwr  = 1'b1;
        c.regdst = (o == OP_R) ? 2'b01 : 2'b00;
      end
      // PCWr here is folded in combinationally from the compare flags.
      S_BRANCH: begin c.srca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; end
      S_JUMP:   begin c.pcsrc = 2'b10; c.pcwr = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_nxt = S_FETCH;
    case (r_state)
      S_FETCH: w_nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)                    w_nxt = S_MEMADR;
        else if (w_r_ok || op == OP_ORI || op == OP_LUI)   w_nxt = S_EXEC;
        else if (w_is_br)                                  w_nxt = S_BRANCH;
        else if (op == OP_J)                               w_nxt = S_JUMP;
        else                                               w_nxt = S_FETCH;
      end
      S_MEMADR: w_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_nxt = S_MEMWB;
      S_EXEC:   w_nxt = S_ALUWB;
      default:  w_nxt = S_FETCH;
    endcase
  end

  assign w_nxt_ctrl = ctrl_for(w_nxt, op, funct);
  assign w_rst_ctrl = ctrl_for(S_FETCH, op, funct);

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWR) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= w_rst_ctrl;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_nxt;
      r_ctrl  <= w_nxt_ctrl;
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  assign PCWr     = r_ctrl.pcwr | ((r_state == S_BRANCH) & w_take);
  assign IRWr     = r_ctrl.irwr;
  assign RegWr    = r_ctrl.regwr;
  assign MemWr    = r_ctrl.memwr;
  assign RegDst   = r_ctrl.regdst;
  assign ALUSrcA  = r_ctrl.srca;
  assign ALUSrcB  = r_ctrl.srcb;
  assign ExtOp    = r_ctrl.extop;
  assign MemToReg = r_ctrl.memtoreg;
  assign PCSrc    = r_ctrl.pcsrc;
  assign ALUOp    = r_ctrl.aluop;
  assign state    = r_state;
  assign retired  = r_retired;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: op  in  6  instruction [31:26]; funct  in  6  instruction [5:0]; zero  in  3  ALU compare flags {A>B, A==B, A<B}.
REQ-003 SHALL have outputs: PCWr 1, IRWr 1, RegWr 1, MemWr 1, RegDst 2 (00 rt, 01 rd), ALUSrcA 1 (0 PC, 1 regA), ALUSrcB 2 (00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2), ExtOp 1 (1 sign, 0 zero), MemToReg 1, PCSrc 2 (00 ALU result, 01 ALUOut, 10 jump target), ALUOp 3, state 4, retired 32.
REQ-004 SHALL use ALUOp encodings: 000 add, 001 sub, 010 and, 011 or, 100 lui (B[15:0]<<16).

Function
REQ-005 SHALL decode opcodes: R-type 000000 (funct addu 100001, subu 100011, and 100100, or 100101), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
REQ-006 SHALL implement a Moore FSM: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9; state output = current encoding.
REQ-007 FETCH: IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00; next DECODE.
REQ-008 DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=000 (branch target to ALUOut); next lw/sw->MEMADR, R/ori/lui->EXEC, beq->BRANCH, j->JUMP, any other op or unlisted R funct->FETCH.
REQ-009 MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000; next lw->MEMRD, sw->MEMWR.
REQ-010 MEMRD -> MEMWB; MEMWB: RegWr=1, RegDst=00, MemToReg=1 -> FETCH; MEMWR: MemWr=1 -> FETCH.
REQ-011 EXEC: ALUSrcA=1; R-type ALUSrcB=00, ALUOp per funct; ori ALUSrcB=10, ExtOp=0, ALUOp=011; lui ALUSrcB=10, ALUOp=100; next ALUWB.
REQ-012 ALUWB: RegWr=1, MemToReg=0, RegDst=01 for R-type else 00 -> FETCH.
REQ-013 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, PCWr=zero[1] (combinational, same cycle) -> FETCH.
REQ-014 JUMP: PCSrc=10, PCWr=1 -> FETCH.
REQ-015 Outputs not listed for a state SHALL be 0; RegWr, MemWr, PCWr, IRWr never asserted outside stated states.
REQ-016 Latency: lw 5 cycles, sw/R/ori/lui 4, beq/j 3, illegal 2 (no writes besides FETCH PC+4).
REQ-017 retired SHALL increment by 1 on the final cycle of every legal instruction (MEMWB, MEMWR, ALUWB, BRANCH taken or not, JUMP); wraps 0xFFFFFFFF->0; illegal instructions not counted.

Reset
REQ-018 reset high at a clk edge SHALL force state=FETCH, retired=0, overriding any in-flight instruction; no RegWr/MemWr in the cycle following reset.
REQ-019 During reset assertion, outputs SHALL reflect FETCH decode after the first edge; reset mid-lw SHALL abandon MEMRD/MEMWB.

Configuration
REQ-020 Macro MC_CTRL_BNE_EN: defined -> op 000101 (bne) SHALL go DECODE->BRANCH with PCWr=~zero[1], counted in retired; undefined -> 000101 illegal per REQ-008.

Verification
REQ-021 reset 1 cycle, then op=100011 -> state 0,1,2,3,4,0; RegWr=1 and MemToReg=1 only in state 4; retired=1.
REQ-022 op=000000 funct=100011 -> EXEC ALUOp=001, ALUSrcB=00; ALUWB RegDst=01, RegWr=1; 4 cycles.
REQ-023 op=000100, zero=3'b010 in BRANCH -> PCWr=1, PCSrc=01; repeat zero=3'b100 -> PCWr=0; retired +2.
REQ-024 op=111111 -> FETCH, DECODE, FETCH; RegWr=MemWr=0 throughout; retired unchanged.
REQ-025 reset asserted while state=3 (lw) -> next state 0, retired=0, no MemToReg write.
REQ-026 with MC_CTRL_BNE_EN, op=000101, zero=3'b001 -> PCWr=1; without macro -> DECODE->FETCH, retired unchanged.
